// File: rtl/rr_arb_stage.sv
// Round-robin arbiter feeding a one-entry output register.
// N_REQ valid/ready requesters share one WIDTH-bit downstream port.
module rr_arb_stage #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(N_REQ)-1:0]      out_src,
    input  logic                          out_ready
);

    localparam int SEL_WIDTH = $clog2(N_REQ);
    localparam logic [SEL_WIDTH:0]   N_EXT    = (SEL_WIDTH+1)'(N_REQ);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(N_REQ - 1);

    logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0] out_src_q, out_src_d;

    logic [SEL_WIDTH-1:0] grant_idx;
    logic                 any_req;
    logic                 load;
    logic                 accept;
    logic [SEL_WIDTH:0]   cand;
    logic [WIDTH-1:0]     sel_data;

    // Scan from rr_ptr upward with wrap; the extra bit in cand lets a
    // single subtraction wrap correctly for non-power-of-two N_REQ.
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (SEL_WIDTH+1)'(k);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!any_req && req_valid[cand[SEL_WIDTH-1:0]]) begin
                any_req   = 1'b1;
                grant_idx = cand[SEL_WIDTH-1:0];
            end
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign accept   = load && any_req;
    assign sel_data = req_data[grant_idx];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = any_req;
            if (any_req) begin
                out_data_d = sel_data;
                out_src_d  = grant_idx;
                rr_ptr_d   = (grant_idx == LAST_IDX) ? '0 : grant_idx + SEL_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: doc/rr_arb_stage.md
# rr_arb_stage

Round-robin arbiter plus one-entry output register that shares a single WIDTH-bit downstream port among N_REQ valid/ready requesters. It is used wherever several producers contend for one shared path, such as writeback or a shared functional-unit port. Each cycle it computes a grant and drives the encoded select into the existing `mux2`/N-input mux datapath. It then registers the winning payload with its source index. The grant rotates after every accepted transfer, so no requester starves while it holds valid high.

## Interface
- WIDTH, 32, payload width per requester
- N_REQ, 4, number of requesters; 2..16, need not be a power of two
- SEL_WIDTH, $clog2(N_REQ), localparam, width of grant/source index
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester valid
- req_data  input  [N_REQ-1:0][WIDTH-1:0]  per-requester payload
- req_ready  output  N_REQ  per-requester accept; at most one bit high
- out_valid  output  1  registered output holds a transfer
- out_data  output  WIDTH  registered payload
- out_src  output  SEL_WIDTH  index of the requester that produced out_data
- out_ready  input  1  downstream accepts out_data this cycle

## Operation
- State:
  - rr_ptr (SEL_WIDTH): highest-priority index
  - out_valid/out_data/out_src register
- load = !out_valid || out_ready. The output slot is free or being drained this cycle.
- Grant (combinational): the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... N_REQ-1, 0, ... rr_ptr-1.
  - any_req = |req_valid.
  - The grant index feeds the payload mux select.
- req_ready[g] = load && any_req, for the granted g only. All other bits are 0.
- Accept (load && any_req) on the clock edge:
  - out_data <= req_data[g]
  - out_src <= g
  - out_valid <= 1
  - rr_ptr <= (g == N_REQ-1) ? 0 : g+1. The explicit wrap is required for non-power-of-two N_REQ.
- load && !any_req: out_valid <= 0. out_data, out_src and rr_ptr hold.
- !load (out_valid && !out_ready): all state holds and every req_ready bit is 0.
- Requester rule: once req_valid[i] rises, it and req_data[i] stay stable until req_ready[i]. Violations are undefined; the bench asserts against them.
- Downstream rule: out_data and out_src stay stable while out_valid && !out_ready.
- Reset: out_valid=0, out_data=0, out_src=0, rr_ptr=0. req_ready follows as 0 while any_req=0.
- rst overrides any simultaneous accept. A transfer whose req_ready was high during the rst cycle is not captured. The requester must treat it as not accepted.

## Timing
- Latency: 1 cycle from the accepted req_valid && req_ready edge to out_valid.
- Throughput: 1 transfer/cycle while out_ready is held high.
- Simultaneous drain and fill in one cycle is legal: out_valid stays 1 and new data loads.
- Combinational paths:
  - req_valid → req_ready
  - out_ready → req_ready
- No other path from input to output is combinational. out_* come only from flops.
- Fairness: with all N_REQ requesters continuously valid and no backpressure, each is granted exactly once in any N_REQ consecutive accepts.

## Test plan
- Reset then idle:
  - rst high 2 cycles, then low, all req_valid=0.
  - Required: out_valid=0, out_data=0, out_src=0 and req_ready=0 in every cycle.
- Single requester:
  - req_valid=4'b0100, req_data[2]=32'hDEAD_BEEF, out_ready=1.
  - Required: req_ready=4'b0100 in the same cycle. Next cycle: out_valid=1, out_data=DEADBEEF, out_src=2, and rr_ptr becomes 3.
- Rotation:
  - All 4 valid continuously, out_ready=1, data[i]=i+0x10.
  - Required: out_src sequence 0,1,2,3,0,1,... with out_data 0x10,0x11,0x12,0x13,... one per cycle.
- Backpressure:
  - As in Rotation, but drop out_ready for 3 cycles after the first output.
  - Required: out_data=0x10 and out_src=0 held, req_ready=0 throughout the stall.
  - On release: out_src=1 arrives the next cycle. No duplicates and no drops.
- Wrap with N_REQ=3:
  - Requesters 0 and 2 continuously valid.
  - Required: grants alternate 0,2,0,2. rr_ptr goes 2→0 after granting index 2 and never reaches 3.
- Reset mid-stream:
  - Assert rst while out_valid=1 and req_ready[1]=1.
  - Required: next cycle out_valid=0 and rr_ptr=0. The first grant after reset goes to the lowest valid index.
